unidade_load_store: RTL and testbench

//  Load/store unit between the MEM-stage control and the word-addressed data memory (async read, sync write).

---
 rtl/unidade_load_store.sv | 175 +++++++++++++++++
 tb/tb_unidade_load_store.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_load_store.sv
// Load/store unit between the MEM-stage control and a word-addressed data memory.
// Turns byte-addressed sub-word loads/stores into word accesses, with read-modify-write for sub-word stores.
module unidade_load_store #(
    parameter int MEM_AW      = 26,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              op_escrita,
    input  logic [1:0]        tamanho,
    input  logic              com_sinal,
    input  logic [MEM_AW+1:0] endereco_byte,
    input  logic [31:0]       dado_entrada,
    output logic              ocupado,
    output logic              pronto,
    output logic              erro_alinhamento,
    output logic [31:0]       dado_saida,
    output logic [MEM_AW-1:0] mem_endereco,
    output logic              mem_memWrite,
    output logic [31:0]       mem_dado_Escrito,
    input  logic [31:0]       mem_dado_Lido
);

    localparam logic [1:0] TAM_BYTE = 2'b00;
    localparam logic [1:0] TAM_HALF = 2'b01;
    localparam logic [1:0] TAM_WORD = 2'b10;
    localparam logic [1:0] TAM_RES  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW,
        STORE,
        DONE,
        DONE_ERR
    } estado_t;

    estado_t estado, proximo;

    logic [1:0]        addr_q;
    logic [1:0]        tam_q;
    logic              sinal_q;
    logic [15:0]       dado_q;
    logic [31:0]       dado_saida_q;
    logic [MEM_AW-1:0] mem_endereco_q;
    logic [31:0]       mem_dado_escrito_q;

    logic [1:0]  tam_efetivo;
    logic        desalinhado;
    logic        aceita;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] valor_carga;
    logic [31:0] palavra_mesclada;

    // Without alignment checking the reserved size degrades to a plain word access.
    always_comb begin
        tam_efetivo = tamanho;
        if (!ALIGN_CHECK && tamanho == TAM_RES)
            tam_efetivo = TAM_WORD;
    end

    always_comb begin
        desalinhado = 1'b0;
        if (ALIGN_CHECK) begin
            case (tamanho)
                TAM_HALF: desalinhado = endereco_byte[0];
                TAM_WORD: desalinhado = (endereco_byte[1:0] != 2'b00);
                TAM_RES:  desalinhado = 1'b1;
                default:  desalinhado = 1'b0;
            endcase
        end
    end

    assign aceita = (estado == IDLE) && req;

    // Little-endian lane selection from the word currently presented by memory.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q)
            2'd0: byte_sel = mem_dado_Lido[7:0];
            2'd1: byte_sel = mem_dado_Lido[15:8];
            2'd2: byte_sel = mem_dado_Lido[23:16];
            2'd3: byte_sel = mem_dado_Lido[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_q[1] ? mem_dado_Lido[31:16] : mem_dado_Lido[15:0];
    end

    always_comb begin
        valor_carga = mem_dado_Lido;
        case (tam_q)
            TAM_BYTE: valor_carga = {{24{sinal_q & byte_sel[7]}}, byte_sel};
            TAM_HALF: valor_carga = {{16{sinal_q & half_sel[15]}}, half_sel};
            default:  valor_carga = mem_dado_Lido;
        endcase
    end

    always_comb begin
        palavra_mesclada = mem_dado_Lido;
        case (tam_q)
            TAM_BYTE: palavra_mesclada[8*addr_q +: 8] = dado_q[7:0];
            TAM_HALF: palavra_mesclada[16*addr_q[1] +: 16] = dado_q;
            default:  palavra_mesclada = mem_dado_Lido;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= IDLE;
        else
            estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        case (estado)
            IDLE: begin
                if (req) begin
                    if (desalinhado)
                        proximo = DONE_ERR;
                    else if (!op_escrita)
                        proximo = LOAD;
                    else if (tam_efetivo == TAM_WORD)
                        proximo = STORE;
                    else
                        proximo = RMW;
                end
            end
            LOAD:     proximo = DONE;
            RMW:      proximo = STORE;
            STORE:    proximo = DONE;
            DONE:     proximo = IDLE;
            DONE_ERR: proximo = IDLE;
            default:  proximo = IDLE;
        endcase
    end

    // An aborted request leaves the address and write-data registers untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q             <= 2'b00;
            tam_q              <= 2'b00;
            sinal_q            <= 1'b0;
            dado_q             <= 16'h0000;
            dado_saida_q       <= 32'h0000_0000;
            mem_endereco_q     <= '0;
            mem_dado_escrito_q <= 32'h0000_0000;
        end else begin
            if (aceita && !desalinhado) begin
                addr_q         <= endereco_byte[1:0];
                tam_q          <= tam_efetivo;
                sinal_q        <= com_sinal;
                dado_q         <= dado_entrada[15:0];
                mem_endereco_q <= endereco_byte[MEM_AW+1:2];
                if (op_escrita && tam_efetivo == TAM_WORD)
                    mem_dado_escrito_q <= dado_entrada;
            end
            if (estado == LOAD)
                dado_saida_q <= valor_carga;
            if (estado == RMW)
                mem_dado_escrito_q <= palavra_mesclada;
        end
    end

    assign ocupado          = (estado != IDLE);
    assign pronto           = (estado == DONE) || (estado == DONE_ERR);
    assign erro_alinhamento = (estado == DONE_ERR);
    assign mem_memWrite     = (estado == STORE);
    assign dado_saida       = dado_saida_q;
    assign mem_endereco     = mem_endereco_q;
    assign mem_dado_Escrito = mem_dado_escrito_q;

endmodule

// File: tb/tb_unidade_load_store.sv
// Self-checking bench for unidade_load_store: a vector table fed through a scoreboard queue,
// plus hand-written sequences for held requests and reset during read-modify-write.
module tb_unidade_load_store;

    localparam int MEM_AW = 26;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic              op_escrita = 1'b0;
    logic [1:0]        tamanho = 2'b00;
    logic              com_sinal = 1'b0;
    logic [MEM_AW+1:0] endereco_byte = '0;
    logic [31:0]       dado_entrada = 32'h0;
    logic              ocupado;
    logic              pronto;
    logic              erro_alinhamento;
    logic [31:0]       dado_saida;
    logic [MEM_AW-1:0] mem_endereco;
    logic              mem_memWrite;
    logic [31:0]       mem_dado_Escrito;
    logic [31:0]       mem_dado_Lido;

    logic [31:0] mem [0:15] = '{32'h80FF7F01, 32'h11223344, 32'h0, 32'h01020304,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0};
    int n_escritas = 0;
    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        logic        op_escrita;
        logic [1:0]  tamanho;
        logic        com_sinal;
        logic [27:0] endereco;
        logic [31:0] dado;
        logic        exp_erro;
        int          exp_lat;
        logic [31:0] exp_saida;
        int          exp_escritas;
        int          idx;
        logic [31:0] exp_mem;
    } vetor_t;

    vetor_t vetores [0:18];
    vetor_t fila_esperada [$];

    unidade_load_store #(.MEM_AW(MEM_AW), .ALIGN_CHECK(1'b1)) dut (
        .clock            (clock),
        .reset            (reset),
        .req              (req),
        .op_escrita       (op_escrita),
        .tamanho          (tamanho),
        .com_sinal        (com_sinal),
        .endereco_byte    (endereco_byte),
        .dado_entrada     (dado_entrada),
        .ocupado          (ocupado),
        .pronto           (pronto),
        .erro_alinhamento (erro_alinhamento),
        .dado_saida       (dado_saida),
        .mem_endereco     (mem_endereco),
        .mem_memWrite     (mem_memWrite),
        .mem_dado_Escrito (mem_dado_Escrito),
        .mem_dado_Lido    (mem_dado_Lido)
    );

    always #5 clock = ~clock;

    // Behavioural data memory: combinational read, write on the rising edge.
    assign mem_dado_Lido = mem[mem_endereco[3:0]];

    always @(posedge clock) begin
        if (mem_memWrite) begin
            mem[mem_endereco[3:0]] <= mem_dado_Escrito;
            n_escritas <= n_escritas + 1;
        end
    end

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    task automatic check_output(input int lat, input int escritas);
        vetor_t e;
        if (fila_esperada.size() == 0) begin
            n_checks++;
            n_err++;
            $display("[TB] FAIL scoreboard: got empty queue expected a pending entry");
            return;
        end
        e = fila_esperada.pop_front();
        check("latency", lat, e.exp_lat);
        check("erro_alinhamento", {31'b0, erro_alinhamento}, {31'b0, e.exp_erro});
        check("dado_saida", dado_saida, e.exp_saida);
        check("write_count", escritas, e.exp_escritas);
        if (e.idx >= 0)
            check("mem_word", mem[e.idx], e.exp_mem);
    endtask

    // Issues one request for one cycle, then waits (bounded) for pronto.
    task automatic apply_stimulus(input vetor_t v);
        int lat;
        int antes;
        @(negedge clock);
        op_escrita    = v.op_escrita;
        tamanho       = v.tamanho;
        com_sinal     = v.com_sinal;
        endereco_byte = v.endereco;
        dado_entrada  = v.dado;
        req           = 1'b1;
        antes         = n_escritas;
        fila_esperada.push_back(v);
        @(negedge clock);
        req = 1'b0;
        lat = 1;
        while (!pronto && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check_output(lat, n_escritas - antes);
    endtask

    initial begin
        int lat;
        int antes;

        vetores[0]  = '{1'b0, 2'b00, 1'b1, 28'd3,  32'h0,        1'b0, 2, 32'hFFFFFF80, 0, -1, 32'h0};
        vetores[1]  = '{1'b0, 2'b00, 1'b0, 28'd0,  32'h0,        1'b0, 2, 32'h00000001, 0, -1, 32'h0};
        vetores[2]  = '{1'b0, 2'b00, 1'b0, 28'd1,  32'h0,        1'b0, 2, 32'h0000007F, 0, -1, 32'h0};
        vetores[3]  = '{1'b0, 2'b00, 1'b1, 28'd2,  32'h0,        1'b0, 2, 32'hFFFFFFFF, 0, -1, 32'h0};
        vetores[4]  = '{1'b0, 2'b01, 1'b1, 28'd2,  32'h0,        1'b0, 2, 32'hFFFF80FF, 0, -1, 32'h0};
        vetores[5]  = '{1'b0, 2'b01, 1'b0, 28'd2,  32'h0,        1'b0, 2, 32'h000080FF, 0, -1, 32'h0};
        vetores[6]  = '{1'b0, 2'b01, 1'b1, 28'd0,  32'h0,        1'b0, 2, 32'h00007F01, 0, -1, 32'h0};
        vetores[7]  = '{1'b0, 2'b10, 1'b0, 28'd0,  32'h0,        1'b0, 2, 32'h80FF7F01, 0, -1, 32'h0};
        vetores[8]  = '{1'b1, 2'b00, 1'b0, 28'd5,  32'hFFFFFFAB, 1'b0, 3, 32'h80FF7F01, 1, 1,  32'h1122AB44};
        vetores[9]  = '{1'b1, 2'b01, 1'b0, 28'd6,  32'h1234BEEF, 1'b0, 3, 32'h80FF7F01, 1, 1,  32'hBEEFAB44};
        vetores[10] = '{1'b0, 2'b10, 1'b0, 28'd4,  32'h0,        1'b0, 2, 32'hBEEFAB44, 0, -1, 32'h0};
        vetores[11] = '{1'b0, 2'b01, 1'b1, 28'd1,  32'h0,        1'b1, 1, 32'hBEEFAB44, 0, -1, 32'h0};
        vetores[12] = '{1'b1, 2'b10, 1'b0, 28'd2,  32'hDEADBEEF, 1'b1, 1, 32'hBEEFAB44, 0, 0,  32'h80FF7F01};
        vetores[13] = '{1'b0, 2'b11, 1'b0, 28'd0,  32'h0,        1'b1, 1, 32'hBEEFAB44, 0, -1, 32'h0};
        vetores[14] = '{1'b1, 2'b10, 1'b0, 28'd8,  32'hCAFEF00D, 1'b0, 2, 32'hBEEFAB44, 1, 2,  32'hCAFEF00D};
        vetores[15] = '{1'b0, 2'b10, 1'b0, 28'd8,  32'h0,        1'b0, 2, 32'hCAFEF00D, 0, -1, 32'h0};
        vetores[16] = '{1'b1, 2'b00, 1'b0, 28'd8,  32'h1234565A, 1'b0, 3, 32'hCAFEF00D, 1, 2,  32'hCAFEF05A};
        vetores[17] = '{1'b0, 2'b00, 1'b0, 28'd11, 32'h0,        1'b0, 2, 32'h000000CA, 0, -1, 32'h0};
        vetores[18] = '{1'b0, 2'b01, 1'b1, 28'd10, 32'h0,        1'b0, 2, 32'hFFFFCAFE, 0, -1, 32'h0};

        repeat (2) @(negedge clock);
        check("reset_ctrl", {28'b0, ocupado, pronto, erro_alinhamento, mem_memWrite}, 32'h0);
        check("reset_dado_saida", dado_saida, 32'h0);
        check("reset_mem_endereco", {6'b0, mem_endereco}, 32'h0);
        check("reset_mem_dado_Escrito", mem_dado_Escrito, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++)
            apply_stimulus(vetores[i]);

        // Request held high across a sub-word store: exactly one access, then a second one after pronto.
        @(negedge clock);
        op_escrita    = 1'b1;
        tamanho       = 2'b00;
        com_sinal     = 1'b0;
        endereco_byte = '0;
        dado_entrada  = 32'h00000077;
        req           = 1'b1;
        antes         = n_escritas;
        @(negedge clock);
        lat = 1;
        while (!pronto && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check("held_latency", lat, 3);
        check("held_first_writes", n_escritas - antes, 1);
        check("held_first_mem", mem[0], 32'h80FF7F77);
        dado_entrada = 32'h00000066;
        @(negedge clock);
        check("held_idle_gap", {31'b0, ocupado}, 32'h0);
        @(negedge clock);
        check("held_second_accept", {31'b0, ocupado}, 32'h1);
        req = 1'b0;
        lat = 0;
        while (!pronto && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check("held_second_done", {31'b0, pronto}, 32'h1);
        check("held_total_writes", n_escritas - antes, 2);
        check("held_second_mem", mem[0], 32'h80FF7F66);

        // Reset in the middle of a read-modify-write must abort without writing.
        @(negedge clock);
        op_escrita    = 1'b1;
        tamanho       = 2'b00;
        endereco_byte = 28'd12;
        dado_entrada  = 32'h000000EE;
        req           = 1'b1;
        antes         = n_escritas;
        @(negedge clock);
        req   = 1'b0;
        reset = 1'b1;
        #1;
        check("rmw_reset_ctrl", {28'b0, ocupado, pronto, erro_alinhamento, mem_memWrite}, 32'h0);
        check("rmw_reset_dado_saida", dado_saida, 32'h0);
        check("rmw_reset_mem_endereco", {6'b0, mem_endereco}, 32'h0);
        check("rmw_reset_mem_dado_Escrito", mem_dado_Escrito, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rmw_reset_writes", n_escritas - antes, 0);
        check("rmw_reset_mem", mem[3], 32'h01020304);
        check("rmw_reset_idle", {31'b0, ocupado}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
